// File: rtl/servo_pkg.sv
// Shared servo constants and the position-to-pulse-width mapping.
package servo_pkg;

  localparam int POS_W = 8;
  localparam int FC_W  = 20;

  localparam int FRAME_CYCLES_DEF = 1_000_000;
  localparam int MIN_PULSE_DEF    = 50_000;
  localparam int STEP_DEF         = 196;

  localparam logic [POS_W-1:0] POS_LOCKED = 8'd0;
  localparam logic [POS_W-1:0] POS_OPEN   = 8'd200;

  function automatic logic [FC_W-1:0] pulse_width(input logic [POS_W-1:0] pos,
                                                  input logic [FC_W-1:0]  min_pulse,
                                                  input logic [FC_W-1:0]  step);
    return min_pulse + FC_W'(pos) * step;
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// PWM frame counter; parks at zero while disabled so a re-enable starts a fresh frame.
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  output logic [FC_W-1:0] fc,
  output logic            frame_start,
  output logic            frame_end
);

  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      fc <= '0;
    end else if (fc == FC_LAST) begin
      fc <= '0;
    end else begin
      fc <= fc + 1'b1;
    end
  end

  assign frame_start = enable && (fc == '0);
  assign frame_end   = enable && (fc == FC_LAST);

endmodule

// File: rtl/servo_ramp_pwm.sv
// Bolt servo driver: 50 Hz PWM whose width tracks a slew-limited copy of the command.
module servo_ramp_pwm
  import servo_pkg::*;
#(
  parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter int MIN_PULSE    = MIN_PULSE_DEF,
  parameter int STEP         = STEP_DEF,
  parameter int RAMP_DIV     = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [POS_W-1:0] position,
  output logic             servo,
  output logic             frame_start,
  output logic [POS_W-1:0] cur_position,
  output logic             at_target
);

  if (MIN_PULSE + 255 * STEP >= FRAME_CYCLES) begin : g_bad_cfg
    $error("servo_ramp_pwm: widest pulse does not fit inside one frame");
  end

  localparam logic [FC_W-1:0] MIN_PW    = FC_W'(MIN_PULSE);
  localparam logic [FC_W-1:0] STEP_PW   = FC_W'(STEP);
  localparam logic [15:0]     RAMP_LAST = (RAMP_DIV == 0) ? 16'd0 : 16'(RAMP_DIV - 1);

  logic [FC_W-1:0]  fc;
  logic             frame_tick;
  logic             frame_end;
  logic [FC_W-1:0]  pw_q;
  logic [POS_W-1:0] target_q;
  logic [15:0]      ramp_cnt;
  logic [POS_W-1:0] next_cur;
  logic [POS_W-1:0] next_target;
  logic [15:0]      next_cnt;

  servo_frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fc         (fc),
    .frame_start(frame_tick),
    .frame_end  (frame_end)
  );

  // Position only ever moves on a frame boundary, one LSB per RAMP_DIV frames.
  always_comb begin
    next_cur    = cur_position;
    next_cnt    = ramp_cnt;
    next_target = frame_end ? position : target_q;
    if (frame_end) begin
      if (RAMP_DIV == 0) begin
        next_cur = position;
      end else if (ramp_cnt == RAMP_LAST) begin
        next_cnt = '0;
        if (cur_position < position) begin
          next_cur = cur_position + 1'b1;
        end else if (cur_position > position) begin
          next_cur = cur_position - 1'b1;
        end
      end else begin
        next_cnt = ramp_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_position <= '0;
      target_q     <= '0;
      ramp_cnt     <= '0;
      pw_q         <= MIN_PW;
      servo        <= 1'b0;
      frame_start  <= 1'b0;
      at_target    <= 1'b1;
    end else begin
      cur_position <= next_cur;
      target_q     <= next_target;
      ramp_cnt     <= next_cnt;
      if (frame_end) begin
        pw_q <= pulse_width(next_cur, MIN_PW, STEP_PW);
      end
      servo       <= enable && (fc < pw_q);
      frame_start <= frame_tick;
      at_target   <= (next_cur == next_target);
    end
  end

endmodule

// File: tb/tb_servo_ramp_pwm.sv
// Directed bench: three servo drivers (RAMP_DIV 1, 0, 3) on short frames for sim speed.
module tb_servo_ramp_pwm;

  logic            clk;
  logic [2:0]      rst;
  logic [2:0]      en;
  logic [2:0][7:0] pos;
  logic [2:0]      servo_o;
  logic [2:0]      fs_o;
  logic [2:0]      at_o;
  logic [2:0][7:0] cur_o;

  int n_cmp = 0;
  int n_bad = 0;

  servo_ramp_pwm #(.FRAME_CYCLES(1000), .MIN_PULSE(50), .STEP(2), .RAMP_DIV(1)) u_div1 (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .position(pos[0]),
    .servo(servo_o[0]), .frame_start(fs_o[0]), .cur_position(cur_o[0]), .at_target(at_o[0]));

  servo_ramp_pwm #(.FRAME_CYCLES(1000), .MIN_PULSE(50), .STEP(2), .RAMP_DIV(0)) u_div0 (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .position(pos[1]),
    .servo(servo_o[1]), .frame_start(fs_o[1]), .cur_position(cur_o[1]), .at_target(at_o[1]));

  servo_ramp_pwm #(.FRAME_CYCLES(1000), .MIN_PULSE(50), .STEP(2), .RAMP_DIV(3)) u_div3 (
    .clk(clk), .rst(rst[2]), .enable(en[2]), .position(pos[2]),
    .servo(servo_o[2]), .frame_start(fs_o[2]), .cur_position(cur_o[2]), .at_target(at_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for a frame_start, then integrates servo over exactly one frame.
  task automatic measure(input int d, input int chg_at, input logic [7:0] chg_pos,
                         output int w, output int at0, output int cur0);
    int t   = 0;
    int nfs = 0;
    while (!fs_o[d] && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("frame_start_timeout", 32'((t >= 3000) ? 1 : 0), 32'd0);
    at0  = int'(at_o[d]);
    cur0 = int'(cur_o[d]);
    w    = 0;
    for (int i = 0; i < 1000; i++) begin
      if (i == chg_at) pos[d] = chg_pos;
      w   += int'(servo_o[d]);
      nfs += int'(fs_o[d]);
      @(negedge clk);
    end
    check("frame_start_per_frame", 32'(nfs), 32'd1);
  endtask

  initial begin
    int w, a, c;
    int exp_cur [4];
    rst = 3'b111;
    en  = 3'b000;
    pos = '0;
    tick(2);
    check("rst_servo", 32'(servo_o[0]), 32'd0);
    check("rst_frame_start", 32'(fs_o[0]), 32'd0);
    check("rst_cur_position", 32'(cur_o[0]), 32'd0);
    check("rst_at_target", 32'(at_o[0]), 32'd1);

    // 1: idle at position 0
    en[0]  = 1'b1;
    rst[0] = 1'b0;
    measure(0, -1, 8'd0, w, a, c);
    check("t1_width0", 32'(w), 32'd50);
    check("t1_at0", 32'(a), 32'd1);
    measure(0, -1, 8'd0, w, a, c);
    check("t1_width1", 32'(w), 32'd50);

    // 2: ramp 0 -> 5 one LSB per frame
    pos[0] = 8'd5;
    for (int k = 0; k < 6; k++) begin
      measure(0, -1, 8'd0, w, a, c);
      check($sformatf("t2_width_%0d", k), 32'(w), 32'(50 + 2 * k));
      check($sformatf("t2_cur_%0d", k), 32'(c), 32'(k));
      check($sformatf("t2_at_%0d", k), 32'(a), 32'((k == 0 || k == 5) ? 1 : 0));
    end

    // 4: ramp toward 10, reverse to 3 while at 6
    rst[0] = 1'b1;
    pos[0] = 8'd10;
    tick(1);
    rst[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      measure(0, (k == 6) ? 10 : -1, 8'd3, w, a, c);
      check($sformatf("t4_up_cur_%0d", k), 32'(c), 32'(k));
      check($sformatf("t4_up_width_%0d", k), 32'(w), 32'(50 + 2 * k));
    end
    exp_cur = '{5, 4, 3, 3};
    for (int k = 0; k < 4; k++) begin
      measure(0, -1, 8'd0, w, a, c);
      check($sformatf("t4_down_cur_%0d", k), 32'(c), 32'(exp_cur[k]));
      check($sformatf("t4_down_width_%0d", k), 32'(w), 32'(50 + 2 * exp_cur[k]));
    end

    // 5: enable dropped mid-pulse, then restored
    tick(19);
    check("t5_servo_before_drop", 32'(servo_o[0]), 32'd1);
    en[0] = 1'b0;
    tick(1);
    check("t5_servo_after_drop", 32'(servo_o[0]), 32'd0);
    check("t5_fs_after_drop", 32'(fs_o[0]), 32'd0);
    tick(5);
    check("t5_cur_held", 32'(cur_o[0]), 32'd3);
    check("t5_servo_parked", 32'(servo_o[0]), 32'd0);
    en[0] = 1'b1;
    tick(1);
    check("t5_fs_on_reenable", 32'(fs_o[0]), 32'd1);
    check("t5_servo_on_reenable", 32'(servo_o[0]), 32'd1);
    measure(0, -1, 8'd0, w, a, c);
    check("t5_width_resumed", 32'(w), 32'd56);
    check("t5_cur_resumed", 32'(c), 32'd3);

    // 3: RAMP_DIV=0 jump, command changed mid-frame
    rst[1] = 1'b0;
    en[1]  = 1'b1;
    measure(1, 100, 8'd200, w, a, c);
    check("t3_width_cur_frame", 32'(w), 32'd50);
    check("t3_at_cur_frame", 32'(a), 32'd1);
    measure(1, -1, 8'd0, w, a, c);
    check("t3_width_next_frame", 32'(w), 32'd450);
    check("t3_cur_next_frame", 32'(c), 32'd200);
    check("t3_at_next_frame", 32'(a), 32'd1);

    // 6: RAMP_DIV=3 ramp to 7, reset mid-pulse with ramp_cnt=1
    rst[2] = 1'b0;
    en[2]  = 1'b1;
    pos[2] = 8'd7;
    for (int k = 0; k < 22; k++) measure(2, -1, 8'd0, w, a, c);
    check("t6_cur_before_rst", 32'(cur_o[2]), 32'd7);
    check("t6_at_before_rst", 32'(at_o[2]), 32'd1);
    tick(19);
    check("t6_servo_before_rst", 32'(servo_o[2]), 32'd1);
    rst[2] = 1'b1;
    tick(1);
    rst[2] = 1'b0;
    check("t6_servo_after_rst", 32'(servo_o[2]), 32'd0);
    check("t6_cur_after_rst", 32'(cur_o[2]), 32'd0);
    check("t6_at_after_rst", 32'(at_o[2]), 32'd1);
    check("t6_fs_after_rst", 32'(fs_o[2]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      measure(2, -1, 8'd0, w, a, c);
      check($sformatf("t6_width_%0d", k), 32'(w), 32'((k == 3) ? 52 : 50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
